uart_rx_fifo_writer: RTL and testbench
======================================

UART_RX_FIFO_WRITER -- requirements
Module: uart_rx_fifo_writer

Interface
REQ-001 SHALL have parameter: CLKS_PER_BIT, default 16, wr_clk cycles per serial bit; legal range 4..65535.
REQ-002 SHALL have port: wr_clk  input  1  write-side clock; all logic in this domain.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: rx  input  1  asynchronous serial line, idle high, 8N1, LSB first.
REQ-005 SHALL have port: full  input  1  downstream FIFO full flag, wr_clk domain.
REQ-006 SHALL have port: wr_en  output  1  one-cycle write strobe to downstream FIFO.
REQ-007 SHALL have port: wr_data  output  8  received byte; valid when wr_en=1.
REQ-008 SHALL have port: frame_err  output  1  one-cycle pulse when the stop bit samples low.
REQ-009 SHALL have port: overrun  output  1  one-cycle pulse when a good byte is dropped because full=1.
REQ-010 SHALL have port: overrun_cnt  output  8  saturating count of dropped bytes.

Function
REQ-011 SHALL pass rx through a 2-flop synchronizer; both flops reset to 1; only the second flop output (rx_s) is used.
REQ-012 SHALL implement FSM states IDLE, START, DATA, STOP; a bit-timer counter (width ceil(log2(CLKS_PER_BIT)), minimum 1) and a 3-bit bit index.
REQ-013 IDLE: on rx_s=0 -> START, load timer with CLKS_PER_BIT/2-1 (integer division).
REQ-014 START: on timer=0, sample rx_s; 0 -> DATA with timer=CLKS_PER_BIT-1 and index=0; 1 -> IDLE (glitch reject, no pulse).
REQ-015 DATA: on timer=0, shift rx_s into bit[index] (LSB first), reload timer; after index 7 -> STOP with timer=CLKS_PER_BIT-1.
REQ-016 STOP: on timer=0, sample rx_s; then -> IDLE in the same edge.
REQ-017 Stop sample 1 and full=0 (value at sampling edge): wr_en=1 and wr_data=byte for exactly the next cycle.
REQ-018 Stop sample 1 and full=1: no wr_en; overrun=1 for one cycle; overrun_cnt increments, saturates at 255.
REQ-019 Stop sample 0: no wr_en, no overrun; frame_err=1 for one cycle; byte discarded.
REQ-020 wr_en, overrun, frame_err SHALL be mutually exclusive and never asserted for 2 consecutive cycles.
REQ-021 wr_data SHALL hold the last delivered byte between strobes (changes only with wr_en).
REQ-022 In IDLE, a line held low (break) after a frame_err SHALL start a new frame only after rx_s returns high then falls again.
REQ-023 Back-to-back frames (next start bit immediately after stop bit) SHALL be received without loss.
REQ-024 Latency: wr_en asserts between 2+CLKS_PER_BIT/2+9*CLKS_PER_BIT and that +2 cycles after the rx falling edge of the start bit.
REQ-025 SHALL never assert wr_en while full=1 on the same edge the decision is made.

Reset
REQ-026 On rst_n=0, asynchronously: FSM=IDLE, timer=0, index=0, shift register=0, wr_data=0x00, wr_en=0, frame_err=0, overrun=0, overrun_cnt=0, sync flops=1.
REQ-027 Reset asserted mid-frame SHALL abort the frame with no strobe or error pulse; after release the block waits for a fresh high-to-low rx edge.

Verification
REQ-028 CLKS_PER_BIT=16, full=0, send 0xA5 -> single wr_en pulse, wr_data=0xA5, within REQ-024 window.
REQ-029 Send 0x00,0xFF,0x3C back-to-back, no idle gap -> three wr_en pulses, data in order, no errors.
REQ-030 full=1 throughout, send 0x55 three times -> zero wr_en, three overrun pulses, overrun_cnt=3; 300 bytes -> overrun_cnt=255.
REQ-031 Send 0x81 with stop bit driven low -> frame_err pulse, no wr_en; following good 0x42 -> wr_en with 0x42.
REQ-032 Low glitch of 4 cycles on idle rx -> no pulses, FSM back in IDLE; then a valid 0x7E is received correctly.
REQ-033 Assert rst_n=0 during DATA bit 4 of 0x99, release, send 0x12 -> only wr_en with 0x12, overrun_cnt=0.

Source files
------------

// File: rtl/uart_rx_fifo_writer.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo_writer
//
// Purpose:
//   Receives 8N1 serial bytes (LSB first, idle high) on an asynchronous line
//   and writes each good byte into a downstream FIFO with a single-cycle
//   strobe. Bytes arriving while the FIFO is full are dropped and counted.
//   Bytes whose stop bit samples low are dropped and flagged.
//
// Parameters:
//   CLKS_PER_BIT  wr_clk cycles per serial bit (4..65535)
//
// Ports:
//   wr_clk       in   write-side clock; the whole block runs in this domain
//   rst_n        in   asynchronous active-low reset
//   rx           in   asynchronous serial input, idle high
//   full         in   downstream FIFO full flag
//   wr_en        out  one-cycle write strobe to the FIFO
//   wr_data      out  received byte; valid with wr_en, held between strobes
//   frame_err    out  one-cycle pulse when the stop bit samples low
//   overrun      out  one-cycle pulse when a good byte is dropped (full=1)
//   overrun_cnt  out  saturating count of dropped bytes
// ---------------------------------------------------------------------------
module uart_rx_fifo_writer #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic       wr_clk,
    input  logic       rst_n,
    input  logic       rx,
    input  logic       full,
    output logic       wr_en,
    output logic [7:0] wr_data,
    output logic       frame_err,
    output logic       overrun,
    output logic [7:0] overrun_cnt
);

    // Bit timer wide enough to hold CLKS_PER_BIT-1, never narrower than 1.
    localparam int unsigned TW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

    // Start bit is re-sampled half a bit after its falling edge so every
    // later sample lands near the middle of its bit.
    localparam logic [TW-1:0] HALF_LOAD = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] FULL_LOAD = TW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    logic          rx_meta_q;
    logic          rx_s_q;
    state_t        state_q,  state_d;
    logic [TW-1:0] timer_q,  timer_d;
    logic [2:0]    index_q,  index_d;
    logic [7:0]    shift_q,  shift_d;
    logic          armed_q,  armed_d;
    logic          wr_en_q,  wr_en_d;
    logic [7:0]    wr_data_q, wr_data_d;
    logic          frame_err_q, frame_err_d;
    logic          overrun_q, overrun_d;
    logic [7:0]    overrun_cnt_q, overrun_cnt_d;

    logic          tick;

    assign tick = (timer_q == '0);

    // -----------------------------------------------------------------------
    // Two-flop synchronizer. Both flops reset high so a reset never looks
    // like a start bit.
    // -----------------------------------------------------------------------
    always_ff @(posedge wr_clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    // -----------------------------------------------------------------------
    // FSM process 1: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge wr_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -----------------------------------------------------------------------
    // FSM process 2: next-state logic
    // A start is only accepted while armed, i.e. once the line has been seen
    // high since the previous start or framing error. This keeps a held-low
    // (break) line from retriggering frames.
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (!rx_s_q && armed_q) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                if (tick) begin
                    state_d = rx_s_q ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (tick && (index_q == 3'd7)) begin
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (tick) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM process 3: datapath and output next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        timer_d       = tick ? timer_q : (timer_q - TW'(1));
        index_d       = index_q;
        shift_d       = shift_q;
        armed_d       = armed_q | rx_s_q;
        wr_en_d       = 1'b0;
        wr_data_d     = wr_data_q;
        frame_err_d   = 1'b0;
        overrun_d     = 1'b0;
        overrun_cnt_d = overrun_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (!rx_s_q && armed_q) begin
                    timer_d = HALF_LOAD;
                    armed_d = 1'b0;
                end
            end
            S_START: begin
                // A start bit that is high again at mid-bit was a glitch;
                // return to idle silently.
                if (tick && !rx_s_q) begin
                    timer_d = FULL_LOAD;
                    index_d = 3'd0;
                end
            end
            S_DATA: begin
                if (tick) begin
                    shift_d[index_q] = rx_s_q;
                    timer_d          = FULL_LOAD;
                    index_d          = index_q + 3'd1;
                end
            end
            S_STOP: begin
                if (tick) begin
                    if (rx_s_q) begin
                        if (full) begin
                            overrun_d = 1'b1;
                            if (overrun_cnt_q != 8'hFF) begin
                                overrun_cnt_d = overrun_cnt_q + 8'd1;
                            end
                        end else begin
                            wr_en_d   = 1'b1;
                            wr_data_d = shift_q;
                        end
                    end else begin
                        frame_err_d = 1'b1;
                        // Line is low after a bad stop: require it to go
                        // high before the next start is honoured.
                        armed_d     = 1'b0;
                    end
                end
            end
            default: ;
        endcase
    end

    // -----------------------------------------------------------------------
    // Datapath / output registers
    // -----------------------------------------------------------------------
    always_ff @(posedge wr_clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_q       <= '0;
            index_q       <= 3'd0;
            shift_q       <= 8'h00;
            armed_q       <= 1'b0;
            wr_en_q       <= 1'b0;
            wr_data_q     <= 8'h00;
            frame_err_q   <= 1'b0;
            overrun_q     <= 1'b0;
            overrun_cnt_q <= 8'h00;
        end else begin
            timer_q       <= timer_d;
            index_q       <= index_d;
            shift_q       <= shift_d;
            armed_q       <= armed_d;
            wr_en_q       <= wr_en_d;
            wr_data_q     <= wr_data_d;
            frame_err_q   <= frame_err_d;
            overrun_q     <= overrun_d;
            overrun_cnt_q <= overrun_cnt_d;
        end
    end

    assign wr_en       = wr_en_q;
    assign wr_data     = wr_data_q;
    assign frame_err   = frame_err_q;
    assign overrun     = overrun_q;
    assign overrun_cnt = overrun_cnt_q;

endmodule

// File: tb/tb_uart_rx_fifo_writer.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_fifo_writer
//
// Directed bench for uart_rx_fifo_writer at CLKS_PER_BIT=16. Drives serial
// frames bit by bit, logs every output pulse, and compares pulse counts,
// captured bytes, latency and counter values against hand-derived numbers.
// ---------------------------------------------------------------------------
module tb_uart_rx_fifo_writer;

    localparam int CPB     = 16;
    localparam int LAT_MIN = 2 + CPB / 2 + 9 * CPB;
    localparam int LAT_MAX = LAT_MIN + 2;

    logic       wr_clk = 1'b0;
    logic       rst_n  = 1'b0;
    logic       rx     = 1'b1;
    logic       full   = 1'b0;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       frame_err;
    logic       overrun;
    logic [7:0] overrun_cnt;

    uart_rx_fifo_writer #(.CLKS_PER_BIT(CPB)) dut (
        .wr_clk      (wr_clk),
        .rst_n       (rst_n),
        .rx          (rx),
        .full        (full),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .frame_err   (frame_err),
        .overrun     (overrun),
        .overrun_cnt (overrun_cnt)
    );

    always #5 wr_clk = ~wr_clk;

    int cyc = 0;
    always @(posedge wr_clk) cyc <= cyc + 1;

    // -----------------------------------------------------------------------
    // Checking
    // -----------------------------------------------------------------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // -----------------------------------------------------------------------
    // Output monitor (samples on the falling edge)
    // -----------------------------------------------------------------------
    int         wr_cnt    = 0;
    int         ovr_cnt   = 0;
    int         ferr_cnt  = 0;
    int         viol_cnt  = 0;
    int         hold_viol = 0;
    int         t_wr      = 0;
    int         t_fall    = 0;
    logic       prev_any  = 1'b0;
    logic [7:0] last_data = 8'h00;
    logic [7:0] got_q[$];

    always @(negedge wr_clk) begin
        int s;
        s = int'(wr_en) + int'(overrun) + int'(frame_err);
        if (s > 1) viol_cnt++;
        if (s > 0 && prev_any) viol_cnt++;
        prev_any = (s > 0);
        if (!rst_n) begin
            last_data = 8'h00;
        end else if (wr_en) begin
            wr_cnt++;
            got_q.push_back(wr_data);
            last_data = wr_data;
            t_wr      = cyc;
            $display("[%0d] wr_en data=0x%02h", cyc, wr_data);
        end else if (wr_data !== last_data) begin
            hold_viol++;
        end
        if (overrun) begin
            ovr_cnt++;
            if (ovr_cnt <= 3 || ovr_cnt >= 299)
                $display("[%0d] overrun cnt=%0d", cyc, overrun_cnt);
        end
        if (frame_err) begin
            ferr_cnt++;
            $display("[%0d] frame_err", cyc);
        end
    end

    function automatic logic [31:0] got_at(input int i);
        if (i < got_q.size()) return {24'h0, got_q[i]};
        return 32'hDEAD_BEEF;
    endfunction

    // -----------------------------------------------------------------------
    // Stimulus helpers (called aligned at #1 after a rising edge)
    // -----------------------------------------------------------------------
    task automatic clear_counts();
        wr_cnt   = 0;
        ovr_cnt  = 0;
        ferr_cnt = 0;
        got_q.delete();
    endtask

    task automatic wait_bit();
        repeat (CPB) @(posedge wr_clk);
        #1;
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(posedge wr_clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop_bit);
        rx     = 1'b0;
        t_fall = cyc;
        wait_bit();
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            wait_bit();
        end
        rx = stop_bit;
        wait_bit();
    endtask

    // -----------------------------------------------------------------------
    // Test sequence
    // -----------------------------------------------------------------------
    initial begin
        int lat;
        rst_n = 1'b0;
        rx    = 1'b1;
        full  = 1'b0;
        repeat (3) @(posedge wr_clk);
        #1;
        check_eq("rst_wr_en",       {31'h0, wr_en},     32'h0);
        check_eq("rst_wr_data",     {24'h0, wr_data},   32'h0);
        check_eq("rst_frame_err",   {31'h0, frame_err}, 32'h0);
        check_eq("rst_overrun",     {31'h0, overrun},   32'h0);
        check_eq("rst_overrun_cnt", {24'h0, overrun_cnt}, 32'h0);
        rst_n = 1'b1;
        idle(10);

        // Single byte, latency window
        clear_counts();
        send_byte(8'hA5, 1'b1);
        idle(10);
        lat = t_wr - t_fall;
        $display("latency %0d cycles (window %0d..%0d)", lat, LAT_MIN, LAT_MAX);
        check_eq("a5_wr_count", wr_cnt, 1);
        check_eq("a5_data",     got_at(0), 32'hA5);
        check_eq("a5_latency",  {31'h0, (lat >= LAT_MIN && lat <= LAT_MAX)}, 32'h1);
        check_eq("a5_no_ferr",  ferr_cnt, 0);

        // Back-to-back frames
        clear_counts();
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        send_byte(8'h3C, 1'b1);
        idle(10);
        check_eq("b2b_wr_count", wr_cnt, 3);
        check_eq("b2b_data0",    got_at(0), 32'h00);
        check_eq("b2b_data1",    got_at(1), 32'hFF);
        check_eq("b2b_data2",    got_at(2), 32'h3C);
        check_eq("b2b_no_err",   ferr_cnt + ovr_cnt, 0);

        // Framing error, held break, then recovery
        clear_counts();
        send_byte(8'h81, 1'b0);
        rx = 1'b0;
        repeat (40) @(posedge wr_clk);
        #1;
        idle(20);
        check_eq("ferr_count",    ferr_cnt, 1);
        check_eq("ferr_no_wr",    wr_cnt, 0);
        send_byte(8'h42, 1'b1);
        idle(10);
        check_eq("ferr_recover_count", wr_cnt, 1);
        check_eq("ferr_recover_data",  got_at(0), 32'h42);
        check_eq("ferr_total",         ferr_cnt, 1);

        // Short low glitch on idle line, then a valid byte
        clear_counts();
        rx = 1'b0;
        repeat (4) @(posedge wr_clk);
        #1;
        idle(30);
        check_eq("glitch_no_pulse", wr_cnt + ferr_cnt + ovr_cnt, 0);
        send_byte(8'h7E, 1'b1);
        idle(10);
        check_eq("glitch_after_count", wr_cnt, 1);
        check_eq("glitch_after_data",  got_at(0), 32'h7E);

        // FIFO full: overrun pulses and saturating counter
        clear_counts();
        full = 1'b1;
        for (int i = 0; i < 3; i++) send_byte(8'h55, 1'b1);
        idle(10);
        check_eq("ovr3_no_wr",  wr_cnt, 0);
        check_eq("ovr3_pulses", ovr_cnt, 3);
        check_eq("ovr3_cnt",    {24'h0, overrun_cnt}, 32'd3);
        for (int i = 0; i < 297; i++) send_byte(8'h55, 1'b1);
        idle(10);
        check_eq("ovr300_pulses", ovr_cnt, 300);
        check_eq("ovr300_cnt",    {24'h0, overrun_cnt}, 32'd255);
        check_eq("ovr300_no_wr",  wr_cnt, 0);
        check_eq("ovr_data_held", {24'h0, wr_data}, 32'h7E);
        full = 1'b0;

        // Reset during data bit 4 of 0x99
        clear_counts();
        rx = 1'b0;
        wait_bit();
        for (int i = 0; i < 4; i++) begin
            rx = (i == 0 || i == 3) ? 1'b1 : 1'b0;
            wait_bit();
        end
        rx = 1'b1;
        repeat (CPB / 2) @(posedge wr_clk);
        #1;
        rst_n = 1'b0;
        repeat (3) @(posedge wr_clk);
        #1;
        check_eq("midrst_wr_data", {24'h0, wr_data}, 32'h0);
        check_eq("midrst_cnt",     {24'h0, overrun_cnt}, 32'h0);
        rst_n = 1'b1;
        idle(20);
        send_byte(8'h12, 1'b1);
        idle(10);
        check_eq("midrst_wr_count", wr_cnt, 1);
        check_eq("midrst_data",     got_at(0), 32'h12);
        check_eq("midrst_no_err",   ferr_cnt + ovr_cnt, 0);
        check_eq("midrst_cnt_end",  {24'h0, overrun_cnt}, 32'h0);

        // Global pulse properties over the whole run
        check_eq("pulse_exclusive", viol_cnt, 0);
        check_eq("wr_data_hold",    hold_viol, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
